// File: rtl/jam_cost_loader.sv
// Cost-table fetch stage for the Job Assignment Machine: caches the 8x8 cost ROM and
// serves it through a registered read port. Define LOADER_ROWMIN_EN to enable lb_sum.
module jam_cost_loader #(
    parameter int unsigned COST_W = 7,
    parameter int unsigned SUM_W  = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic              busy,
    output logic              load_done,
    input  logic [2:0]        rd_w,
    input  logic [2:0]        rd_j,
    output logic [COST_W-1:0] rd_cost,
    output logic [SUM_W-1:0]  lb_sum
);

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned ENTRIES = 64;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic              busy_nx, load_done_nx;
    logic              fetch_c, clear_c;
    logic [COST_W-1:0] mem [ENTRIES];

    // ROM address is the fetch pointer itself, so W/J are registered
    assign W = addr[5:3];
    assign J = addr[2:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr      <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            busy      <= busy_nx;
            load_done <= load_done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        busy_nx      = busy;
        load_done_nx = load_done;
        fetch_c      = 1'b0;
        clear_c      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx     = FETCH;
                    addr_nx      = '0;
                    busy_nx      = 1'b1;
                    load_done_nx = 1'b0;
                    clear_c      = 1'b1;
                end
            end
            FETCH: begin
                fetch_c = 1'b1;
                if (addr == ADDR_W'(ENTRIES - 1)) begin
                    state_nx     = DONE;
                    addr_nx      = '0;
                    busy_nx      = 1'b0;
                    load_done_nx = 1'b1;
                end else begin
                    addr_nx = addr + ADDR_W'(1);
                end
            end
            default: begin
                state_nx     = IDLE;
                addr_nx      = '0;
                busy_nx      = 1'b0;
                load_done_nx = 1'b0;
            end
        endcase
    end

    // Cache is intentionally not reset; contents are only meaningful with load_done
    always_ff @(posedge CLK) begin
        if (fetch_c) mem[addr] <= Cost;
    end

    always_ff @(posedge CLK) begin
        if (RST) rd_cost <= '0;
        else     rd_cost <= mem[{rd_w, rd_j}];
    end

`ifdef LOADER_ROWMIN_EN
    logic [COST_W-1:0] rmin;
    logic [COST_W-1:0] row_min_c;

    // Minimum of the current row including the entry arriving this cycle
    always_comb begin
        if (J == 3'd0)        row_min_c = Cost;
        else if (Cost < rmin) row_min_c = Cost;
        else                  row_min_c = rmin;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rmin   <= '0;
            lb_sum <= '0;
        end else if (clear_c) begin
            lb_sum <= '0;
        end else if (fetch_c) begin
            rmin <= row_min_c;
            if (J == 3'd7) lb_sum <= lb_sum + SUM_W'(row_min_c);
        end
    end
`else
    assign lb_sum = '0;
`endif

endmodule

// File: tb/tb_jam_cost_loader.sv
// Self-checking bench for jam_cost_loader; expected lb_sum follows LOADER_ROWMIN_EN.
module tb_jam_cost_loader;

    localparam int unsigned COST_W = 7;
    localparam int unsigned SUM_W  = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [2:0]        W, J, rd_w, rd_j;
    logic [COST_W-1:0] Cost, rd_cost;
    logic              busy, load_done;
    logic [SUM_W-1:0]  lb_sum;

    int rom  [64];
    int snap [64];
    int checks = 0;
    int errors = 0;

    jam_cost_loader #(.COST_W(COST_W), .SUM_W(SUM_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .W(W), .J(J), .Cost(Cost),
        .busy(busy), .load_done(load_done), .rd_w(rd_w), .rd_j(rd_j),
        .rd_cost(rd_cost), .lb_sum(lb_sum)
    );

    // Behavioural ROM: combinational from the current address
    assign Cost = COST_W'(rom[{W, J}]);

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sum over rows of the row minimum, or zero when the feature is compiled out
    function automatic int exp_lb();
        int s = 0;
`ifdef LOADER_ROWMIN_EN
        for (int w = 0; w < 8; w++) begin
            int m = 1000;
            for (int j = 0; j < 8; j++) if (rom[w*8+j] < m) m = rom[w*8+j];
            s += m;
        end
`endif
        return s;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_W"}, int'(W), 0);
        check({tag, "_J"}, int'(J), 0);
        check({tag, "_load_done"}, int'(load_done), 0);
        check({tag, "_lb_sum"}, int'(lb_sum), 0);
        check({tag, "_rd_cost"}, int'(rd_cost), 0);
    endtask

    // Start a fetch; optionally inject extra starts or a reset at a given fetch cycle
    task automatic run_fetch(input int rst_at, input bit extra);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check("fetch_busy", int'(busy), 1);
            check("fetch_W", int'(W), k / 8);
            check("fetch_J", int'(J), k % 8);
            check("fetch_load_done", int'(load_done), 0);
            if (k == rst_at) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                check_reset_vals("mid_rst");
                return;
            end
            if (extra && (k == 10 || k == 40)) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("done_busy", int'(busy), 0);
        check("done_load_done", int'(load_done), 1);
        check("done_W", int'(W), 0);
        check("done_J", int'(J), 0);
        check("lb_sum", int'(lb_sum), exp_lb());
        snap = rom;
    endtask

    task automatic read_chk(input int w, input int j);
        rd_w = 3'(w);
        rd_j = 3'(j);
        tick();
        check("rd_cost", int'(rd_cost), snap[w*8+j]);
    endtask

    // Scramble ROM while in DONE, verify the cache is untouched, then random reads
    task automatic post_checks();
        for (int i = 0; i < 64; i++) rom[i] = int'($urandom_range(0, 127));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold_load_done", int'(load_done), 1);
            check("hold_W", int'(W), 0);
        end
        for (int r = 0; r < 6; r++) read_chk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 0;
        RST = 1'b1; start = 1'b0; rd_w = 3'd0; rd_j = 3'd0;
        tick(); tick(); tick();
        check_reset_vals("reset");
        RST = 1'b0;
        tick();

        // Ramp table 8w+j
        for (int i = 0; i < 64; i++) rom[i] = i;
        run_fetch(-1, 1'b0);
`ifdef LOADER_ROWMIN_EN
        check("lb_ramp_const", int'(lb_sum), 224);
`else
        check("lb_ramp_const", int'(lb_sum), 0);
`endif
        rd_w = 3'd5; rd_j = 3'd3; tick();
        check("rd_5_3", int'(rd_cost), 43);
        rd_w = 3'd7; rd_j = 3'd7; tick();
        check("rd_7_7", int'(rd_cost), 63);
        post_checks();

        // Saturated table: worst-case sum without wrap
        for (int i = 0; i < 64; i++) rom[i] = 127;
        run_fetch(-1, 1'b0);
        post_checks();

        // Only row 3 contributes, via a mid-row minimum
        for (int i = 0; i < 64; i++) rom[i] = 0;
        for (int j = 0; j < 8; j++) rom[24+j] = 127;
        rom[30] = 2;
        run_fetch(-1, 1'b0);
        post_checks();

        // Extra starts during FETCH are ignored
        for (int i = 0; i < 64; i++) rom[i] = i;
        run_fetch(-1, 1'b1);
        post_checks();

        // Reset mid-fetch then complete a clean fetch
        for (int i = 0; i < 64; i++) rom[i] = int'($urandom_range(0, 127));
        run_fetch(30, 1'b0);
        tick();
        check("post_rst_load_done", int'(load_done), 0);
        run_fetch(-1, 1'b0);
        post_checks();

        // Random tables
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 64; i++) rom[i] = int'($urandom_range(0, 127));
            run_fetch(-1, 1'b0);
            post_checks();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jam_cost_loader.md
Name: jam_cost_loader

Overview:
- Upstream fetch stage for the Job Assignment Machine.
- Walks the external 8x8 worker/job cost ROM through the W/J address interface, one entry per cycle, and caches all 64 entries in local registers.
- Serves the cached entries to the downstream permutation/accumulate core through a 1-cycle-latency read port.
- Also produces the sum of per-worker row minima, a lower bound the core can use for branch pruning.

Parameters:
- COST_W, 7, width of one cost entry (matches the Cost bus).
- SUM_W, 10, width of lb_sum and of the downstream MinCost bus.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse; begins a full table fetch.
- W  out  3  ROM worker address, registered.
- J  out  3  ROM job address, registered.
- Cost  in  COST_W  ROM data; combinational from the current W/J, stable before the next rising edge.
- busy  out  1  high while fetching.
- load_done  out  1  level; table and lb_sum valid.
- rd_w  in  3  cache read worker index.
- rd_j  in  3  cache read job index.
- rd_cost  out  COST_W  cached cost for (rd_w, rd_j), registered.
- lb_sum  out  SUM_W  sum over workers of min_j cost[w][j].

Behaviour:
- Reset values: W=0, J=0, busy=0, load_done=0, rd_cost=0, lb_sum=0, state=IDLE, addr=0. Cache contents are not cleared.
- States: IDLE, FETCH, DONE. Internal 6-bit addr; W=addr[5:3], J=addr[2:0] at all times.
- IDLE:
  - start=1 -> FETCH; addr=0, busy=1, lb_sum=0.
  - Otherwise hold.
- FETCH, at each rising edge:
  - mem[addr] <= Cost.
  - Running row minimum: if J==0, rmin<=Cost; else rmin<=min(rmin,Cost).
  - If J==7, lb_sum <= lb_sum + min(rmin,Cost), zero-extended to SUM_W. Worst case 8*127=1016 fits in 10 bits; no overflow handling needed.
  - If addr==63: -> DONE, busy=0, load_done=1, addr wraps to 0. Otherwise addr increments.
- FETCH duration is exactly 64 cycles.
- Latency: start sampled at edge t -> W/J=(0,0) from t. The last entry is captured at edge t+64, and load_done is high from t+64.
- DONE:
  - load_done held high; W=J=0.
  - start=1 -> FETCH as from IDLE; load_done drops at the same edge.
- start while in FETCH is ignored; the fetch continues unchanged.
- Read port:
  - rd_cost <= mem[{rd_w, rd_j}] every cycle, in any state.
  - Data is defined only while load_done=1; during a refetch it may mix old and new entries.
- RST mid-FETCH: at that edge return to IDLE with all outputs at reset values. A partial table is never flagged valid.
- Cost is sampled only in FETCH; Cost is ignored in IDLE and DONE.

Optional Feature:
- LOADER_ROWMIN_EN
- Defined: rmin tracking and lb_sum accumulation are implemented as above.
- Undefined: no rmin/adder logic; lb_sum is tied to 0. The FSM, cache, timing and read port are identical.

Test Plan:
- Table cost[w][j]=8w+j, start pulse -> W/J step (0,0),(0,1)...(7,7) one per cycle; load_done rises 64 cycles after the start edge; busy high exactly 64 cycles; lb_sum=224.
- Same table, then rd_w=5, rd_j=3 -> rd_cost=43 on the next cycle; rd_w=7, rd_j=7 -> 63.
- All entries 127 -> lb_sum=1016 with no wrap. Row 3 all 127 except cost[3][6]=2, others 0 -> lb_sum=2.
- Extra start pulses at cycles 10 and 40 of FETCH -> no effect; load_done still at +64; lb_sum correct.
- RST asserted at fetch cycle 30 -> next edge busy=0, W=J=0, load_done=0, lb_sum=0. A new start then completes in 64 cycles with the correct lb_sum.
- Build without LOADER_ROWMIN_EN, 8w+j table -> lb_sum=0; load_done timing and rd_cost values identical to the first case.
